// File: rtl/bus_t0_codec_pkg.sv
// Shared constants and wrap arithmetic for the T0 bus codec (encoder and decoder).
package bus_t0_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STRIDE = 1;
  localparam int DEF_ACT_W  = 16;
  localparam int MAX_W      = 64;

  // Callers truncate the result to their own WIDTH, which yields the mod 2^WIDTH wrap.
  function automatic logic [MAX_W-1:0] next_seq(input logic [MAX_W-1:0] addr,
                                                input logic [MAX_W-1:0] stride);
    return addr + stride;
  endfunction

endpackage

// File: rtl/bus_t0_codec_dec.sv
// T0 decoder register stage: rebuilds the address from bus + INC; usable stand-alone at a bus receiver.
module bus_t0_dec
  import bus_t0_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STRIDE = DEF_STRIDE
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] dec_o,
  output logic             dec_valid_o
);

  logic [WIDTH-1:0] dec_q, dec_d;
  logic             valid_q;

  always_comb begin
    dec_d = dec_q;
    if (valid_i) begin
      dec_d = inc_i ? WIDTH'(next_seq(MAX_W'(dec_q), MAX_W'(STRIDE))) : bus_i;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      dec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_i;
    end
  end

  assign dec_o       = dec_q;
  assign dec_valid_o = valid_q;

endmodule

// File: rtl/bus_t0_codec.sv
// T0 (zero-transition) address bus encoder with loop-back decoder.
// Optional switching-activity counter on {inc_out,bus_out}: define BUS_T0_CODEC_ACT_EN.
module bus_t0_codec
  import bus_t0_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STRIDE = DEF_STRIDE
`ifdef BUS_T0_CODEC_ACT_EN
  , parameter int ACT_W = DEF_ACT_W
`endif
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a_in,
  input  logic             t0_en,
  output logic [WIDTH-1:0] bus_out,
  output logic             inc_out,
  output logic             enc_valid,
  output logic [WIDTH-1:0] dec_out,
  output logic             dec_valid
`ifdef BUS_T0_CODEC_ACT_EN
  , output logic [ACT_W-1:0] act_cnt
`endif
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             have_prev_q, have_prev_d;
  logic             inc_q, inc_d;
  logic             enc_valid_q;
  logic             seq;

  // NOTE: every _d gets its hold value first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    bus_d       = bus_q;
    inc_d       = inc_q;
    seq = have_prev_q & t0_en & (a_in == WIDTH'(next_seq(MAX_W'(prev_q), MAX_W'(STRIDE))));
    if (in_valid) begin
      prev_d      = a_in;
      have_prev_d = 1'b1;
      inc_d       = seq;
      bus_d       = seq ? bus_q : a_in;
    end
  end

  // NOTE: rst is tested first inside the clocked block, so it is synchronous and overrides in_valid.
  always_ff @(posedge ck) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      bus_q       <= '0;
      inc_q       <= 1'b0;
      enc_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      bus_q       <= bus_d;
      inc_q       <= inc_d;
      enc_valid_q <= in_valid;
    end
  end

  assign bus_out   = bus_q;
  assign inc_out   = inc_q;
  assign enc_valid = enc_valid_q;

  bus_t0_dec #(
    .WIDTH  (WIDTH),
    .STRIDE (STRIDE)
  ) u_dec (
    .ck          (ck),
    .rst         (rst),
    .valid_i     (enc_valid_q),
    .inc_i       (inc_q),
    .bus_i       (bus_q),
    .dec_o       (dec_out),
    .dec_valid_o (dec_valid)
  );

`ifdef BUS_T0_CODEC_ACT_EN
  logic [ACT_W-1:0] act_q, act_d;
  logic [WIDTH:0]   flips;
  logic [ACT_W:0]   sum;

  // One spare sum bit detects overflow; the counter then sticks at all-ones.
  always_comb begin
    flips = {inc_d, bus_d} ^ {inc_q, bus_q};
    sum   = {1'b0, act_q};
    for (int i = 0; i <= WIDTH; i++) begin
      sum = sum + (ACT_W+1)'(flips[i]);
    end
    act_d = act_q;
    if (in_valid) begin
      act_d = sum[ACT_W] ? '1 : sum[ACT_W-1:0];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      act_q <= '0;
    end else begin
      act_q <= act_d;
    end
  end

  assign act_cnt = act_q;
`endif

endmodule

// File: tb/tb_bus_t0_codec.sv
// Self-checking bench: STRIDE=1 and STRIDE=4 codecs driven in parallel against a behavioural model.
module tb_bus_t0_codec;

  localparam int ACT_MAX = 65535;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic       t0_en = 1'b1;

  logic [7:0] bus_w  [2];
  logic [7:0] dec_w  [2];
  logic       inc_w  [2];
  logic       encv_w [2];
  logic       decv_w [2];
`ifdef BUS_T0_CODEC_ACT_EN
  logic [15:0] act_w [2];
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int strd [2] = '{1, 4};
  int m_prev [2], m_have [2], m_bus [2], m_inc [2], m_encv [2];
  int m_acc [2], m_dec [2], m_decv [2], m_act [2];

  always #5 ck = ~ck;

  bus_t0_codec #(.WIDTH(8), .STRIDE(1)) u_s1 (
    .ck (ck), .rst (rst), .in_valid (in_valid), .a_in (a_in), .t0_en (t0_en),
    .bus_out (bus_w[0]), .inc_out (inc_w[0]), .enc_valid (encv_w[0]),
    .dec_out (dec_w[0]), .dec_valid (decv_w[0])
`ifdef BUS_T0_CODEC_ACT_EN
    , .act_cnt (act_w[0])
`endif
  );

  bus_t0_codec #(.WIDTH(8), .STRIDE(4)) u_s4 (
    .ck (ck), .rst (rst), .in_valid (in_valid), .a_in (a_in), .t0_en (t0_en),
    .bus_out (bus_w[1]), .inc_out (inc_w[1]), .enc_valid (encv_w[1]),
    .dec_out (dec_w[1]), .dec_valid (decv_w[1])
`ifdef BUS_T0_CODEC_ACT_EN
    , .act_cnt (act_w[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the decoder output is simply the address accepted on the previous edge.
  task automatic model_edge(input int k);
    int nb, ni, tog;
    bit seq;
    if (rst) begin
      m_prev[k] = 0; m_have[k] = 0; m_bus[k] = 0; m_inc[k] = 0; m_encv[k] = 0;
      m_acc[k] = 0; m_dec[k] = 0; m_decv[k] = 0; m_act[k] = 0;
    end else begin
      m_decv[k] = m_encv[k];
      if (m_encv[k] != 0) m_dec[k] = m_acc[k];
      m_encv[k] = int'(in_valid);
      if (in_valid) begin
        seq = (m_have[k] != 0) && t0_en && (int'(a_in) == (m_prev[k] + strd[k]) % 256);
        ni  = seq ? 1 : 0;
        nb  = seq ? m_bus[k] : int'(a_in);
        tog = $countones(((ni << 8) | nb) ^ ((m_inc[k] << 8) | m_bus[k]));
        m_act[k] = (m_act[k] + tog > ACT_MAX) ? ACT_MAX : m_act[k] + tog;
        m_inc[k] = ni; m_bus[k] = nb;
        m_prev[k] = int'(a_in); m_have[k] = 1; m_acc[k] = int'(a_in);
      end
    end
  endtask

  always @(negedge ck) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("s%0d bus_out", strd[k]), 32'(bus_w[k]), m_bus[k]);
        check($sformatf("s%0d inc_out", strd[k]), 32'(inc_w[k]), m_inc[k]);
        check($sformatf("s%0d enc_valid", strd[k]), 32'(encv_w[k]), m_encv[k]);
        check($sformatf("s%0d dec_out", strd[k]), 32'(dec_w[k]), m_dec[k]);
        check($sformatf("s%0d dec_valid", strd[k]), 32'(decv_w[k]), m_decv[k]);
`ifdef BUS_T0_CODEC_ACT_EN
        check($sformatf("s%0d act_cnt", strd[k]), 32'(act_w[k]), m_act[k]);
`endif
      end
    end
  end

  // Drive at the falling edge, advance one rising edge, update the model just after it.
  task automatic step(input logic r, input logic v, input logic [7:0] a, input logic en);
    rst = r; in_valid = v; a_in = a; t0_en = en;
    @(posedge ck);
    #1;
    model_edge(0);
    model_edge(1);
    @(negedge ck);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int last;
    logic [7:0] a;
    logic r, v, en;
    chk_en = 1'b1;

    // Reset state and the basic stride-1 sequence.
    do_reset();
    check("reset bus_out", 32'(bus_w[0]), 32'h00);
    check("reset dec_valid", 32'(decv_w[0]), 32'h0);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    check("a01 inc", 32'(inc_w[0]), 32'h0);
    check("a01 bus", 32'(bus_w[0]), 32'h01);
    step(1'b0, 1'b1, 8'h02, 1'b1);
    check("a02 inc", 32'(inc_w[0]), 32'h1);
    check("a02 bus", 32'(bus_w[0]), 32'h01);
    check("a02 dec", 32'(dec_w[0]), 32'h01);
    step(1'b0, 1'b1, 8'h03, 1'b1);
    check("a03 inc", 32'(inc_w[0]), 32'h1);
    check("a03 dec", 32'(dec_w[0]), 32'h02);
    idle();
    check("a03 dec later", 32'(dec_w[0]), 32'h03);
    idle();

    // Wrap-around counts as sequential.
    do_reset();
    step(1'b0, 1'b1, 8'hFE, 1'b1);
    check("aFE inc", 32'(inc_w[0]), 32'h0);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("aFF inc", 32'(inc_w[0]), 32'h1);
    check("aFE dec", 32'(dec_w[0]), 32'hFE);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("wrap inc", 32'(inc_w[0]), 32'h1);
    check("wrap bus", 32'(bus_w[0]), 32'hFE);
    check("aFF dec", 32'(dec_w[0]), 32'hFF);
    idle();
    check("wrap dec", 32'(dec_w[0]), 32'h00);

    // Stride 4.
    do_reset();
    step(1'b0, 1'b1, 8'h10, 1'b1);
    check("s4 a10 inc", 32'(inc_w[1]), 32'h0);
    step(1'b0, 1'b1, 8'h14, 1'b1);
    check("s4 a14 inc", 32'(inc_w[1]), 32'h1);
    check("s4 a14 bus", 32'(bus_w[1]), 32'h10);
    step(1'b0, 1'b1, 8'h20, 1'b1);
    check("s4 a20 inc", 32'(inc_w[1]), 32'h0);
    check("s4 a20 bus", 32'(bus_w[1]), 32'h20);
    step(1'b0, 1'b1, 8'h24, 1'b1);
    check("s4 a24 inc", 32'(inc_w[1]), 32'h1);
    check("s4 a24 bus", 32'(bus_w[1]), 32'h20);

    // Mode bit off then on.
    do_reset();
    step(1'b0, 1'b1, 8'h10, 1'b0);
    step(1'b0, 1'b1, 8'h11, 1'b0);
    check("bin a11 inc", 32'(inc_w[0]), 32'h0);
    check("bin a11 bus", 32'(bus_w[0]), 32'h11);
    step(1'b0, 1'b1, 8'h12, 1'b1);
    check("t0 a12 inc", 32'(inc_w[0]), 32'h1);

    // Idle gap keeps the sequence; reset mid-stream clears history.
    do_reset();
    step(1'b0, 1'b1, 8'h30, 1'b1);
    idle();
    check("gap enc_valid", 32'(encv_w[0]), 32'h0);
    check("gap dec", 32'(dec_w[0]), 32'h30);
    idle();
    idle();
    check("gap dec hold", 32'(dec_w[0]), 32'h30);
    step(1'b0, 1'b1, 8'h31, 1'b1);
    check("after gap inc", 32'(inc_w[0]), 32'h1);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'h01, 1'b1);
    check("first after rst inc", 32'(inc_w[0]), 32'h0);
    check("first after rst bus", 32'(bus_w[0]), 32'h01);

`ifdef BUS_T0_CODEC_ACT_EN
    do_reset();
    step(1'b0, 1'b1, 8'h00, 1'b1);
    step(1'b0, 1'b1, 8'hFF, 1'b1);
    check("act plain", 32'(act_w[0]), 32'd8);
    step(1'b0, 1'b1, 8'h00, 1'b1);
    check("act seq", 32'(act_w[0]), 32'd9);
    do_reset();
    for (int i = 0; i < 8200; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 8'h00 : 8'hFF, 1'b0);
    end
    check("act saturated", 32'(act_w[0]), 32'hFFFF);
`endif

    // Randomised traffic biased toward sequential runs of either stride.
    do_reset();
    last = 0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      en = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 3))
        0, 3:    a = 8'(last + 1);
        1:       a = 8'(last + 4);
        default: a = 8'($urandom_range(0, 255));
      endcase
      if (v) last = int'(a);
      step(r, v, a, en);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_t0_codec.md
Name: bus_t0_codec

Overview:
Parametrised T0 (zero-transition) bus codec for low-power address buses. Encoder side: when the new address equals the previous address + STRIDE, the bus is frozen and the INC line is raised; otherwise the address is driven in plain binary. Decoder side: reconstructs the address from bus + INC in the same block, giving a loop-back pair for power-estimation runs. Generalises the fixed 8-bit, stride-1 T0 codec with width/stride parameters, valid qualification, a first-address flag and a run-time mode bit.

Parameters:
WIDTH, 8, address/bus width in bits (>=2)
STRIDE, 1, sequential increment, range 1..2^WIDTH-1, applied modulo 2^WIDTH
ACT_W, 16, activity counter width (optional feature only)

Ports:
ck  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  a_in carries a new address this cycle
a_in  input  WIDTH  address to encode
t0_en  input  1  1 = T0 encoding, 0 = plain binary (INC forced 0)
bus_out  output  WIDTH  encoded bus, registered
inc_out  output  1  T0 line, registered
enc_valid  output  1  bus_out/inc_out updated this cycle
dec_out  output  WIDTH  reconstructed address, registered
dec_valid  output  1  dec_out updated this cycle
act_cnt  output  ACT_W  toggle count on {inc_out,bus_out} (only with BUS_T0_CODEC_ACT_EN)

Behaviour:
- Reset: synchronous, active-high. Sampled at ck edge; rst=1 wins over every other input. After reset: bus_out=0, inc_out=0, enc_valid=0, dec_out=0, dec_valid=0, act_cnt=0, prev=0, have_prev=0.
- Encoder state: prev (WIDTH) holds the last accepted address; have_prev (1) is set by the first accepted address.
- Sequential test: seq = have_prev & t0_en & (a_in == (prev + STRIDE) mod 2^WIDTH). The sum is truncated to WIDTH, so wrap-around counts as sequential (e.g. 0xFF -> 0x00, STRIDE=1).
- On in_valid=1:
  - prev <= a_in, have_prev <= 1, enc_valid <= 1.
  - If seq: inc_out <= 1 and bus_out holds its value.
  - Else: inc_out <= 0 and bus_out <= a_in.
- On in_valid=0: enc_valid <= 0; bus_out, inc_out, prev and have_prev hold. Idle gaps do not break a sequence.
- The first address after reset is never T0-encoded, even if a_in == STRIDE.
- t0_en may change on any cycle; it takes effect for the address sampled that cycle.
- Decoder: on enc_valid=1, dec_valid <= 1 and:
  - if inc_out: dec_out <= dec_out + STRIDE (mod 2^WIDTH);
  - else: dec_out <= bus_out.
  On enc_valid=0: dec_valid <= 0 and dec_out holds.
- Latency: a_in -> bus_out/inc_out is 1 cycle; a_in -> dec_out is 2 cycles. Throughput: one address per cycle.
- Invariant: every decoded value equals the address accepted 2 cycles earlier.
- No backpressure; the block is always ready.

Optional Feature:
- Macro: BUS_T0_CODEC_ACT_EN.
- When defined: act_cnt is an ACT_W-bit counter. Each cycle with enc_valid=1, it adds popcount of the XOR between the new and previous {inc_out,bus_out}. It saturates at all-ones and is cleared only by rst. Used for switching-activity comparison against binary encoding.
- When undefined: the act_cnt port is absent, and no counter or popcount logic is generated.

Decomposition:
- Package bus_t0_pkg: default WIDTH/STRIDE/ACT_W constants, plus a function next_seq(addr, stride) returning the truncated sum. The function is shared by encoder and decoder so both use identical wrap arithmetic.
- One sub-module: bus_t0_dec (decoder register stage), instantiated once. It is reusable stand-alone on the receiving end of a real bus.

Test Plan:
- Reset, then valid addresses 0x01, 0x02, 0x03 (WIDTH=8, STRIDE=1) -> inc_out 0,1,1; bus_out 0x01,0x01,0x01; dec_out 0x01,0x02,0x03 two cycles after each input.
- Addresses 0xFE, 0xFF, 0x00 -> inc_out 0,1,1; dec_out 0xFE, 0xFF, 0x00 (wrap).
- STRIDE=4: addresses 0x10, 0x14, 0x20, 0x24 -> inc_out 0,1,0,1; bus_out 0x10,0x10,0x20,0x20.
- t0_en=0 with 0x10, 0x11 -> inc_out 0,0 and bus_out 0x10, 0x11. Then t0_en=1 with 0x12 -> inc_out 1.
- Sequence 0x30, idle 3 cycles, 0x31 -> 0x31 encoded with inc_out=1; enc_valid low during the gap; dec_out holds 0x30 through the gap. rst pulsed mid-stream, then 0x01 -> inc_out 0.
- With BUS_T0_CODEC_ACT_EN: 0x00 then 0xFF (plain) -> act_cnt=8. A following 0x00 is sequential (inc_out=1, bus frozen) -> act_cnt=9. Forcing the counter near saturation -> it holds at all-ones.
